// File: rtl/tv80_alu16_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tv80_alu16_seq_pkg
//  Description : Shared definitions for the 16-bit ALU sequencer. Holds the
//                F register bit positions, the ALU_Op codes understood by
//                tv80_alu, the request opcode encoding, the sequencer states
//                and a helper that picks the ALU controls for each pass.
//  Revision    : 1.0 - initial release
// ============================================================================
package tv80_alu16_seq_pkg;

    // F register bit positions (identical to tv80_alu)
    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_X = 3;
    localparam int FLAG_H = 4;
    localparam int FLAG_Y = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    // tv80_alu ALU_Op codes used by the 16-bit sequences
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_ADC = 4'b0001;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;
    localparam logic [3:0] ALU_OP_SBC = 4'b0011;

    // Request opcode encoding on req_op
    typedef enum logic [1:0] {
        REQ_ADD16 = 2'b00,
        REQ_ADC16 = 2'b01,
        REQ_SBC16 = 2'b10,
        REQ_INC16 = 2'b11
    } req_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Per-pass control bundle for the ALU
    typedef struct packed {
        logic [3:0] op;
        logic       arith16;
        logic       z16;
    } alu_ctl_t;

    // ADD16 (and INC16) runs ADD on the low byte and ADC on the high byte with
    // Arith16 so S/Z/P come through untouched from the CPU F. ADC16/SBC16 use
    // the same op on both bytes; Z16 on the high pass folds in the low-byte Z
    // so the final Z reflects the whole 16-bit result.
    function automatic alu_ctl_t alu_ctl(input req_op_e op, input logic hi_pass);
        alu_ctl_t c;
        c = '0;
        case (op)
            REQ_ADC16: begin
                c.op  = ALU_OP_ADC;
                c.z16 = hi_pass;
            end
            REQ_SBC16: begin
                c.op  = ALU_OP_SBC;
                c.z16 = hi_pass;
            end
            default: begin
                c.op      = hi_pass ? ALU_OP_ADC : ALU_OP_ADD;
                c.arith16 = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tv80_alu16_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : tv80_alu16_seq_if
//  Description : Bundle of all signals around the 16-bit ALU sequencer:
//                request/response handshake towards the microcode sequencer
//                and the drive/return lines towards the shared tv80_alu.
//                master : environment (sequencer side plus the ALU instance)
//                slave  : the tv80_alu16_seq block
//  Ports       : req_valid/req_ready/req_op/req_a/req_b/req_f  - request
//                rsp_valid/rsp_ready/rsp_q/rsp_f              - response
//                alu_op/alu_arith16/alu_z16/alu_ir/alu_iset/
//                alu_bus_a/alu_bus_b/alu_f_in                 - ALU drive
//                alu_q/alu_f_out                              - ALU return
//  Revision    : 1.0 - initial release
// ============================================================================
interface tv80_alu16_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_f;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_q;
    logic [7:0]  rsp_f;

    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [5:0]  alu_ir;
    logic [1:0]  alu_iset;
    logic [7:0]  alu_bus_a;
    logic [7:0]  alu_bus_b;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;

    modport master (
        output req_valid, req_op, req_a, req_b, req_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_f,
        input  alu_op, alu_arith16, alu_z16, alu_ir, alu_iset,
        input  alu_bus_a, alu_bus_b, alu_f_in,
        output alu_q, alu_f_out
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_f, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_f,
        output alu_op, alu_arith16, alu_z16, alu_ir, alu_iset,
        output alu_bus_a, alu_bus_b, alu_f_in,
        input  alu_q, alu_f_out
    );

endinterface
`default_nettype wire

// File: rtl/tv80_alu16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tv80_alu16_seq
//  Description : Initiator for the TV80 8-bit ALU. Takes one 16-bit
//                ADD/ADC/SBC HL,rr request, runs the ALU over the low byte
//                then the high byte (flags of the low pass feed the high
//                pass) and presents the 16-bit result and final F until the
//                consumer takes it. IDLE -> LO -> HI -> DONE -> IDLE.
//  Ports       : clk, reset (asynchronous, active high)
//                bus (tv80_alu16_seq_if.slave) - request/response handshake
//                and the tv80_alu drive/return signals
//  Options     : TV80_ALU16_INC_EN - req_op 11 becomes INC16 (b = 0x0001,
//                F returned unchanged); otherwise req_op 11 acts as ADD16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tv80_alu16_seq
    import tv80_alu16_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    tv80_alu16_seq_if.slave bus
);

    state_e      state_q,     state_d;
    req_op_e     op_q,        op_d;
    logic [15:0] a_q,         a_d;
    logic [15:0] b_q,         b_d;
    logic [7:0]  f_q,         f_d;
    logic [7:0]  flo_q,       flo_d;
    logic [7:0]  res_lo_q,    res_lo_d;
    logic [15:0] rsp_q_q,     rsp_q_d;
    logic [7:0]  rsp_f_q,     rsp_f_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;

    req_op_e     req_op_dec;
    logic [15:0] req_b_dec;

    // Request decode at the accept point; the optional INC16 is folded into
    // the ADD16 sequence with a forced second operand.
    always_comb begin
        req_op_dec = req_op_e'(bus.req_op);
        req_b_dec  = bus.req_b;
`ifdef TV80_ALU16_INC_EN
        if (req_op_dec == REQ_INC16) begin
            req_b_dec = 16'h0001;
        end
`else
        if (req_op_dec == REQ_INC16) begin
            req_op_dec = REQ_ADD16;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        f_d      = f_q;
        flo_d    = flo_q;
        res_lo_d = res_lo_q;
        rsp_q_d  = rsp_q_q;
        rsp_f_d  = rsp_f_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = req_op_dec;
                    a_d     = bus.req_a;
                    b_d     = req_b_dec;
                    f_d     = bus.req_f;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                res_lo_d = bus.alu_q;
                flo_d    = bus.alu_f_out;
                state_d  = ST_HI;
            end
            ST_HI: begin
                // The response is only updated here, as a whole, so a
                // half-finished result is never visible on rsp_q.
                rsp_q_d = {bus.alu_q, res_lo_q};
                rsp_f_d = (op_q == REQ_INC16) ? f_q : bus.alu_f_out;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next state
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= REQ_ADD16;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            flo_q       <= '0;
            res_lo_q    <= '0;
            rsp_q_q     <= '0;
            rsp_f_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            flo_q       <= flo_d;
            res_lo_q    <= res_lo_d;
            rsp_q_q     <= rsp_q_d;
            rsp_f_q     <= rsp_f_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // ALU drive is combinational from the state registers so the ALU result
    // is ready to be captured on the edge that ends each pass.
    logic       hi_pass;
    logic       busy;
    alu_ctl_t   ctl;
    logic [3:0] alu_op_c;
    logic       alu_arith16_c;
    logic       alu_z16_c;
    logic [7:0] alu_bus_a_c;
    logic [7:0] alu_bus_b_c;
    logic [7:0] alu_f_in_c;

    assign hi_pass = (state_q == ST_HI);
    assign busy    = (state_q == ST_LO) || (state_q == ST_HI);
    assign ctl     = alu_ctl(op_q, hi_pass);

    always_comb begin
        alu_op_c      = '0;
        alu_arith16_c = 1'b0;
        alu_z16_c     = 1'b0;
        alu_bus_a_c   = '0;
        alu_bus_b_c   = '0;
        alu_f_in_c    = '0;
        if (busy) begin
            alu_op_c      = ctl.op;
            alu_arith16_c = ctl.arith16;
            alu_z16_c     = ctl.z16;
            alu_bus_a_c   = hi_pass ? a_q[15:8] : a_q[7:0];
            alu_bus_b_c   = hi_pass ? b_q[15:8] : b_q[7:0];
            alu_f_in_c    = hi_pass ? flo_q     : f_q;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_q       = rsp_q_q;
    assign bus.rsp_f       = rsp_f_q;
    assign bus.alu_op      = alu_op_c;
    assign bus.alu_arith16 = alu_arith16_c;
    assign bus.alu_z16     = alu_z16_c;
    assign bus.alu_ir      = 6'b000000;
    assign bus.alu_iset    = 2'b00;
    assign bus.alu_bus_a   = alu_bus_a_c;
    assign bus.alu_bus_b   = alu_bus_b_c;
    assign bus.alu_f_in    = alu_f_in_c;

endmodule
`default_nettype wire

// File: tb/tb_tv80_alu16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tv80_alu16_seq
//  Description : Self-checking bench for tv80_alu16_seq. A behavioural model
//                of the tv80_alu arithmetic ops sits behind the block; a
//                whole-word 16-bit model produces the expected results,
//                which are queued at issue and compared at response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tv80_alu16_seq;
    import tv80_alu16_seq_pkg::*;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  f;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    tv80_alu16_seq_if ifc ();

    tv80_alu16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Behavioural tv80_alu, arithmetic group (ALU_Op 0..3) only
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic arith16,
                                              input logic z16, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] fin);
        logic       sub, cin, c7;
        logic [7:0] bb, q, f, s7;
        logic [8:0] s;
        logic [4:0] hs;
        sub = op[1];
        cin = op[1] ^ (~op[2] & op[0] & fin[FLAG_C]);
        bb  = sub ? ~b : b;
        hs  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0, cin};
        s7  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'b0, cin};
        s   = {1'b0, a} + {1'b0, bb} + {8'b0, cin};
        c7  = s7[7];
        q   = s[7:0];
        f   = fin;
        f[FLAG_N] = sub;
        f[FLAG_C] = s[8] ^ sub;
        f[FLAG_H] = hs[4] ^ sub;
        f[FLAG_P] = s[8] ^ c7;
        f[FLAG_X] = q[3];
        f[FLAG_Y] = q[5];
        f[FLAG_Z] = (q == 8'h00) ? (z16 ? fin[FLAG_Z] : 1'b1) : 1'b0;
        f[FLAG_S] = q[7];
        if (arith16) begin
            f[FLAG_S] = fin[FLAG_S];
            f[FLAG_Z] = fin[FLAG_Z];
            f[FLAG_P] = fin[FLAG_P];
        end
        return {f, q};
    endfunction

    assign {ifc.alu_f_out, ifc.alu_q} = alu_model(ifc.alu_op, ifc.alu_arith16, ifc.alu_z16,
                                                  ifc.alu_bus_a, ifc.alu_bus_b, ifc.alu_f_in);

    // Whole-word reference for the 16-bit instructions
    function automatic exp_t ref16(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [7:0] f);
        exp_t        e;
        logic [16:0] r;
        logic [12:0] h;
        logic [15:0] bb;
        logic [1:0]  k;
        logic        cy, keep;
        k    = op;
        bb   = b;
        cy   = f[FLAG_C];
        keep = 1'b0;
        if (k == 2'b11) begin
`ifdef TV80_ALU16_INC_EN
            bb   = 16'h0001;
            keep = 1'b1;
`endif
            k = 2'b00;
        end
        e.f = f;
        case (k)
            2'b00: begin
                r = {1'b0, a} + {1'b0, bb};
                h = {1'b0, a[11:0]} + {1'b0, bb[11:0]};
                e.f[FLAG_N] = 1'b0;
            end
            2'b01: begin
                r = {1'b0, a} + {1'b0, bb} + {16'b0, cy};
                h = {1'b0, a[11:0]} + {1'b0, bb[11:0]} + {12'b0, cy};
                e.f[FLAG_N] = 1'b0;
                e.f[FLAG_S] = r[15];
                e.f[FLAG_Z] = (r[15:0] == 16'h0000);
                e.f[FLAG_P] = (a[15] == bb[15]) && (r[15] != a[15]);
            end
            default: begin
                r = {1'b0, a} - {1'b0, bb} - {16'b0, cy};
                h = {1'b0, a[11:0]} - {1'b0, bb[11:0]} - {12'b0, cy};
                e.f[FLAG_N] = 1'b1;
                e.f[FLAG_S] = r[15];
                e.f[FLAG_Z] = (r[15:0] == 16'h0000);
                e.f[FLAG_P] = (a[15] != bb[15]) && (r[15] != a[15]);
            end
        endcase
        e.f[FLAG_C] = r[16];
        e.f[FLAG_H] = h[12];
        e.f[FLAG_X] = r[11];
        e.f[FLAG_Y] = r[13];
        e.q = r[15:0];
        if (keep) begin
            e.f = f;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request; returns on the negedge after the accept edge (LO)
    task automatic issue_op(input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [7:0] f);
        int n;
        n = 0;
        while (ifc.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready before issue", 32'(ifc.req_ready), 32'd1);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_a     = a;
        ifc.req_b     = b;
        ifc.req_f     = f;
        sb.push_back(ref16(op, a, b, f));
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    // Called right after issue_op; expects rsp_valid on the third edge
    task automatic wait_valid(input string tag);
        int n;
        n = 1;
        while (ifc.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd3);
    endtask

    task automatic take_rsp(input string tag, output logic [15:0] q, output logic [7:0] f);
        exp_t e;
        q = ifc.rsp_q;
        f = ifc.rsp_f;
        check({tag, " scoreboard has entry"}, 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, " q"}, 32'(q), 32'(e.q));
        check({tag, " f"}, 32'(f), 32'(e.f));
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] f,
                          output logic [15:0] q, output logic [7:0] fo);
        issue_op(op, a, b, f);
        wait_valid(tag);
        take_rsp(tag, q, fo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        logic [7:0]  f;
        exp_t        e_bp;

        reset         = 1'b1;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'b00;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.req_f     = '0;
        ifc.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("reset req_ready", 32'(ifc.req_ready), 32'd1);
        check("reset rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("reset rsp_q",     32'(ifc.rsp_q),     32'd0);
        check("reset rsp_f",     32'(ifc.rsp_f),     32'd0);
        check("reset alu_op",    32'(ifc.alu_op),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD16 with a look at the low-pass drive
        issue_op(2'b00, 16'h1234, 16'h0FFF, 8'hC5);
        check("lo alu_op",      32'(ifc.alu_op),      32'h0);
        check("lo alu_arith16", 32'(ifc.alu_arith16), 32'd1);
        check("lo alu_bus_b",   32'(ifc.alu_bus_b),   32'hFF);
        check("lo alu_f_in",    32'(ifc.alu_f_in),    32'hC5);
        wait_valid("add16");
        take_rsp("add16", q, f);
        check("add16 q const", 32'(q), 32'h2233);
        check("add16 f const", 32'(f), 32'hF4);

        run_op("sbc16 neg", 2'b10, 16'h0000, 16'h0001, 8'h01, q, f);
        check("sbc16 neg q const",     32'(q), 32'hFFFE);
        check("sbc16 neg flags const", 32'(f & 8'hD3), 32'h93);

        run_op("adc16 ovf", 2'b01, 16'h8000, 16'h8000, 8'h00, q, f);
        check("adc16 ovf q const",     32'(q), 32'h0000);
        check("adc16 ovf flags const", 32'(f & 8'h45), 32'h45);

        run_op("sbc16 zero", 2'b10, 16'h0100, 16'h00FF, 8'h01, q, f);
        check("sbc16 zero q const", 32'(q), 32'h0000);
        check("sbc16 zero Z const", 32'(f[FLAG_Z]), 32'd1);

        run_op("sbc16 nz", 2'b10, 16'h0005, 16'h0000, 8'h00, q, f);
        check("sbc16 nz q const", 32'(q), 32'h0005);
        check("sbc16 nz Z const", 32'(f[FLAG_Z]), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op("random", 2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
                   8'($urandom), q, f);
        end

        // Back-pressure: result must hold while a new request is offered
        e_bp = ref16(2'b01, 16'h1111, 16'h2222, 8'h01);
        issue_op(2'b01, 16'h1111, 16'h2222, 8'h01);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            ifc.req_valid = 1'b1;
            ifc.req_op    = 2'b10;
            ifc.req_a     = 16'hDEAD + 16'(i);
            ifc.req_b     = 16'hBEEF;
            @(negedge clk);
            check("bp rsp_valid", 32'(ifc.rsp_valid), 32'd1);
            check("bp rsp_q",     32'(ifc.rsp_q),     32'(e_bp.q));
            check("bp rsp_f",     32'(ifc.rsp_f),     32'(e_bp.f));
            check("bp req_ready", 32'(ifc.req_ready), 32'd0);
        end
        ifc.req_valid = 1'b0;
        take_rsp("bp", q, f);
        check("bp released rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("bp released req_ready", 32'(ifc.req_ready), 32'd1);

        // Reset in the high pass
        issue_op(2'b00, 16'hABCD, 16'h1357, 8'h00);
        @(negedge clk);
        check("hi alu_op",    32'(ifc.alu_op),    32'h1);
        check("hi alu_bus_a", 32'(ifc.alu_bus_a), 32'hAB);
        #1 reset = 1'b1;
        #1;
        check("midreset req_ready",   32'(ifc.req_ready),   32'd1);
        check("midreset rsp_valid",   32'(ifc.rsp_valid),   32'd0);
        check("midreset rsp_q",       32'(ifc.rsp_q),       32'd0);
        check("midreset rsp_f",       32'(ifc.rsp_f),       32'd0);
        check("midreset alu_op",      32'(ifc.alu_op),      32'd0);
        check("midreset alu_arith16", 32'(ifc.alu_arith16), 32'd0);
        check("midreset alu_bus_a",   32'(ifc.alu_bus_a),   32'd0);
        check("midreset alu_f_in",    32'(ifc.alu_f_in),    32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("post reset add16", 2'b00, 16'h1234, 16'h0FFF, 8'hC5, q, f);
        check("post reset q const", 32'(q), 32'h2233);
        check("post reset f const", 32'(f), 32'hF4);

        // req_op 11
        run_op("op11", 2'b11, 16'hFFFF, 16'h1234, 8'h00, q, f);
`ifdef TV80_ALU16_INC_EN
        check("op11 inc q const", 32'(q), 32'h0000);
        check("op11 inc f const", 32'(f), 32'h00);
`else
        check("op11 add q const", 32'(q), 32'h1233);
        check("op11 add f const", 32'(f), 32'h11);
`endif

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
